note_source_sequencer: RTL and testbench
========================================

NOTE_SOURCE_SEQUENCER -- requirements
Module: note_source_sequencer

Interface
REQ-001 Parameter MUTE_CYCLES, default 16: mute length, in clk cycles, applied on every mode change (legal range 1..255).
REQ-002 Parameter UART_HOLD, default 50000: number of clk cycles a received UART note keeps sounding (legal range 1..2^20-1).
REQ-003 clk  input  1  the single system clock; every register is clocked on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 mode_req  input  2  requested mode: FREE=0, PLAY=1, UART=2, LEARN=3.
REQ-006 pin_note  input  10  one-hot note from the keys: [6:0] note, [9:7] pitch.
REQ-007 db_note  input  10  one-hot note from the song-memory playback.
REQ-008 learn_note  input  10  target note for the learn mode.
REQ-009 uart_byte  input  8  received UART byte.
REQ-010 uart_valid  input  1  one-cycle strobe that qualifies uart_byte.
REQ-011 cur_mode  output  2  committed mode.
REQ-012 note_out  output  10  one-hot note to the buzzer, LED and VGA.
REQ-013 busy  output  1  high while a mode change is in progress.
REQ-014 hit  output  1  one-cycle pulse on a correct key press in LEARN mode.

Function
REQ-015 The FSM SHALL have three states: RUN, MUTE, COMMIT.
REQ-016 In RUN, when mode_req != cur_mode: latch pending=mode_req, load cnt=MUTE_CYCLES-1, go to MUTE.
REQ-017 In MUTE: note_out=0, busy=1, cnt decrements each cycle; at cnt==0 go to COMMIT.
REQ-018 A change of mode_req during MUTE SHALL update pending and reload cnt=MUTE_CYCLES-1.
REQ-019 If mode_req returns to cur_mode during MUTE, the mute SHALL still complete; COMMIT is then a no-op.
REQ-020 COMMIT lasts one cycle: cur_mode<=pending, note_out=0, busy=1; the FSM then returns to RUN.
REQ-021 The earliest first sounding cycle after a mode change SHALL be MUTE_CYCLES+2 cycles after mode_req changes.
REQ-022 In RUN, note_out SHALL be registered with 1-cycle latency from the source selected by cur_mode:
- FREE: pin_note
- PLAY: db_note
- UART: uart_note
- LEARN: pin_note
REQ-023 UART decode: uart_byte[2:0]=k (1..7) sets note bit k-1; uart_byte[4:3]=p (0..2) sets pitch bit 7+p; k==0 or p==3 SHALL decode to all zeros.
REQ-024 On uart_valid, uart_note SHALL load the decoded value and the hold counter SHALL load UART_HOLD; the counter decrements each cycle and uart_note clears when it reaches 0.
REQ-025 A new uart_valid during a hold SHALL replace the note and restart the hold.
REQ-026 UART decode and hold SHALL run in every mode, so a byte received during MUTE sounds after COMMIT if still held.
REQ-027 hit SHALL pulse for one cycle on the first cycle that cur_mode==LEARN, state==RUN, learn_note!=0 and pin_note==learn_note.
REQ-028 hit SHALL NOT pulse again until the match condition has been false for at least one cycle.
REQ-029 Source inputs that are not one-hot SHALL pass through unchanged; no checking is performed.

Reset
REQ-030 When rst is high: state=RUN, cur_mode=FREE, pending=FREE, note_out=0, busy=0, hit=0, uart_note=0, hold counter=0, cnt=0.
REQ-031 Reset asserted mid-MUTE SHALL abandon the pending change; after release the FSM re-evaluates mode_req from RUN.

Structure
REQ-032 The mode encodings and the note/pitch field widths SHALL live in the shared para package; the shared package already holds the mode definitions.
REQ-033 The UART decode plus hold counter SHALL be one sub-module, uart_note_hold; the FSM and the source mux stay in the top level.

Verification
REQ-034 Reset with mode_req=2 held -> after release busy=1 for 17 cycles (MUTE 16 + COMMIT 1); cur_mode=2 on the COMMIT cycle edge; note_out=0 throughout.
REQ-035 FREE, pin_note=10'b0010_000100 -> note_out equals it one cycle later; change mode_req to PLAY with db_note=10'b1000_000001 -> note_out=0 for 17 cycles, then 10'b1000_000001.
REQ-036 UART mode, UART_HOLD=8, uart_byte=8'h0B (k=3, p=1) -> note_out=10'b0100_000100 for 8 cycles, then 0; uart_byte=8'h18 (p=3) -> note_out stays 0.
REQ-037 In MUTE at cnt=5, mode_req changes from 1 to 3 -> cnt reloads, COMMIT lands 16 cycles later with cur_mode=3.
REQ-038 LEARN, learn_note=10'b0010_000010, pin_note held equal for 5 cycles -> exactly one hit pulse; release then press again -> a second pulse.
REQ-039 rst pulse at MUTE cnt=3 -> outputs return to reset values immediately (asynchronously); no COMMIT occurs before the FSM re-evaluates mode_req.

Source files
------------

// File: rtl/note_source_sequencer_pkg.sv
// note_source_sequencer_pkg
//   Shared definitions for the note source sequencer:
//   - mode encodings (FREE/PLAY/UART/LEARN)
//   - note/pitch field widths and the one-hot note type
//   - sequencer FSM state encoding
//   - UART byte to one-hot note decoder
package note_source_sequencer_pkg;

    localparam int NOTE_W    = 7;                 // one-hot note field [6:0]
    localparam int PITCH_W   = 3;                 // one-hot pitch field [9:7]
    localparam int NOTE_BITS = NOTE_W + PITCH_W;

    typedef logic [NOTE_BITS-1:0] note_t;

    typedef enum logic [1:0] {
        MODE_FREE  = 2'd0,
        MODE_PLAY  = 2'd1,
        MODE_UART  = 2'd2,
        MODE_LEARN = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MUTE   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // byte[2:0] = k selects note bit k-1, byte[4:3] = p selects pitch bit
    // NOTE_W+p. k==0 or p==3 are not valid notes and decode to silence.
    function automatic note_t decode_uart_byte(input logic [7:0] b);
        note_t      n;
        logic [2:0] k;
        logic [1:0] p;
        n = '0;
        k = b[2:0];
        p = b[4:3];
        if (k != 3'd0 && p != 2'd3) begin
            n[int'(k) - 1]      = 1'b1;
            n[NOTE_W + int'(p)] = 1'b1;
        end
        return n;
    endfunction

endpackage

// File: rtl/note_source_sequencer_if.sv
// note_source_sequencer_if
//   Groups the mode request, note sources, UART byte strobe and the
//   sequencer outputs.
//   master: drives mode_req, pin_note, db_note, learn_note, uart_byte,
//           uart_valid; observes cur_mode, note_out, busy, hit.
//   slave : the sequencer side (mirror of master).
interface note_source_sequencer_if;
    import note_source_sequencer_pkg::*;

    logic [1:0] mode_req;
    note_t      pin_note;
    note_t      db_note;
    note_t      learn_note;
    logic [7:0] uart_byte;
    logic       uart_valid;
    logic [1:0] cur_mode;
    note_t      note_out;
    logic       busy;
    logic       hit;

    modport master (
        output mode_req, pin_note, db_note, learn_note, uart_byte, uart_valid,
        input  cur_mode, note_out, busy, hit
    );

    modport slave (
        input  mode_req, pin_note, db_note, learn_note, uart_byte, uart_valid,
        output cur_mode, note_out, busy, hit
    );

endinterface

// File: rtl/note_source_sequencer_uart_note_hold.sv
// uart_note_hold
//   Decodes each received UART byte into a one-hot note and keeps it
//   sounding for UART_HOLD cycles. A new byte replaces the note and
//   restarts the hold. Runs regardless of the sequencer mode.
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     uart_byte   received byte
//     uart_valid  one-cycle strobe qualifying uart_byte
//     uart_note   held one-hot note (zero when the hold has expired)
module uart_note_hold
    import note_source_sequencer_pkg::*;
#(
    parameter int UART_HOLD = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] uart_byte,
    input  logic       uart_valid,
    output note_t      uart_note
);

    localparam logic [19:0] HOLD_LOAD = 20'(UART_HOLD);

    logic [19:0] hold_reg;
    note_t       note_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_reg <= '0;
            note_reg <= '0;
        end else if (uart_valid) begin
            note_reg <= decode_uart_byte(uart_byte);
            hold_reg <= HOLD_LOAD;
        end else if (hold_reg != '0) begin
            hold_reg <= hold_reg - 20'd1;
            // Clearing on the 1->0 step gives exactly UART_HOLD sounding cycles.
            if (hold_reg == 20'd1) begin
                note_reg <= '0;
            end
        end
    end

    assign uart_note = note_reg;

endmodule

// File: rtl/note_source_sequencer.sv
// note_source_sequencer
//   Selects which note source drives the buzzer/LED/VGA. A mode change
//   mutes the output for MUTE_CYCLES cycles plus one commit cycle before
//   the new mode takes effect. In LEARN mode a one-cycle hit pulse marks
//   the key press matching the target note.
//   Ports:
//     clk, rst  clock, asynchronous active-high reset
//     bus       slave side of note_source_sequencer_if:
//               mode_req, pin_note, db_note, learn_note, uart_byte,
//               uart_valid in; cur_mode, note_out, busy, hit out
module note_source_sequencer
    import note_source_sequencer_pkg::*;
#(
    parameter int MUTE_CYCLES = 16,
    parameter int UART_HOLD   = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    note_source_sequencer_if.slave  bus
);

    localparam logic [7:0] MUTE_LOAD = 8'(MUTE_CYCLES - 1);

    state_e     state_reg, state_next;
    mode_e      cur_mode_reg, cur_mode_next;
    mode_e      pending_reg, pending_next;
    logic [7:0] cnt_reg, cnt_next;
    note_t      note_out_reg, note_out_next;
    logic       hit_reg, hit_next;
    logic       match_prev_reg;
    logic       match;
    mode_e      mode_req_m;
    note_t      uart_note;
    note_t      src_note;

    uart_note_hold #(
        .UART_HOLD (UART_HOLD)
    ) u_uart_note_hold (
        .clk        (clk),
        .rst        (rst),
        .uart_byte  (bus.uart_byte),
        .uart_valid (bus.uart_valid),
        .uart_note  (uart_note)
    );

    assign mode_req_m = mode_e'(bus.mode_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_RUN;
            cur_mode_reg   <= MODE_FREE;
            pending_reg    <= MODE_FREE;
            cnt_reg        <= '0;
            note_out_reg   <= '0;
            hit_reg        <= 1'b0;
            match_prev_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cur_mode_reg   <= cur_mode_next;
            pending_reg    <= pending_next;
            cnt_reg        <= cnt_next;
            note_out_reg   <= note_out_next;
            hit_reg        <= hit_next;
            match_prev_reg <= match;
        end
    end

    // Next-state logic
    always_comb begin
        state_next    = state_reg;
        cur_mode_next = cur_mode_reg;
        pending_next  = pending_reg;
        cnt_next      = cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (mode_req_m != cur_mode_reg) begin
                    pending_next = mode_req_m;
                    cnt_next     = MUTE_LOAD;
                    state_next   = ST_MUTE;
                end
            end
            ST_MUTE: begin
                // Any change of the request restarts the full mute, even a
                // return to the current mode (the commit is then a no-op).
                if (mode_req_m != pending_reg) begin
                    pending_next = mode_req_m;
                    cnt_next     = MUTE_LOAD;
                end else if (cnt_reg == 8'd0) begin
                    state_next = ST_COMMIT;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            ST_COMMIT: begin
                cur_mode_next = pending_reg;
                state_next    = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Source mux keyed on the mode in force after this edge, so the first
    // note after a commit already comes from the newly committed source.
    always_comb begin
        src_note = '0;
        case (cur_mode_next)
            MODE_FREE:  src_note = bus.pin_note;
            MODE_PLAY:  src_note = bus.db_note;
            MODE_UART:  src_note = uart_note;
            MODE_LEARN: src_note = bus.pin_note;
            default:    src_note = '0;
        endcase
        note_out_next = (state_next == ST_RUN) ? src_note : '0;
    end

    // Rising-edge detect on the match condition gives one pulse per press.
    always_comb begin
        match = (cur_mode_reg == MODE_LEARN) && (state_reg == ST_RUN) &&
                (bus.learn_note != '0) && (bus.pin_note == bus.learn_note);
        hit_next = match && !match_prev_reg;
    end

    assign bus.cur_mode = cur_mode_reg;
    assign bus.note_out = note_out_reg;
    assign bus.busy     = (state_reg != ST_RUN);
    assign bus.hit      = hit_reg;

endmodule

// File: tb/tb_note_source_sequencer.sv
// tb_note_source_sequencer
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against a behavioural model that tracks "quiet cycles remaining" after a
//   mode request and the time of the last UART byte.
module tb_note_source_sequencer;

    localparam int MUTE = 16;
    localparam int HOLD = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    note_source_sequencer_if bus_if ();

    note_source_sequencer #(
        .MUTE_CYCLES (MUTE),
        .UART_HOLD   (HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int         m_mode;
    int         m_pending;
    int         m_quiet;        // busy cycles still to come; 0 = sounding
    bit         m_match_prev;
    int         m_uart_t;       // cycle index of the last UART byte
    logic [9:0] m_uart_note;
    int         cyc = 0;
    logic [9:0] exp_note;
    logic       exp_hit;

    function automatic logic [9:0] ref_decode(input int b);
        int         k;
        int         p;
        logic [9:0] n;
        k = b % 8;
        p = (b / 8) % 4;
        n = '0;
        if (k > 0 && p < 3) begin
            n = 10'(1 << (k - 1)) | 10'(1 << (7 + p));
        end
        return n;
    endfunction

    function automatic void model_reset();
        m_mode       = 0;
        m_pending    = 0;
        m_quiet      = 0;
        m_match_prev = 1'b0;
        m_uart_t     = -1000000;
        m_uart_note  = '0;
    endfunction

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s got=%h want=%h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        logic [9:0] uart_pre;
        logic [9:0] src;
        bit         match;
        int         req;
        cyc++;
        req = int'(bus_if.mode_req);
        uart_pre = (cyc - m_uart_t >= 1 && cyc - m_uart_t <= HOLD) ? m_uart_note : 10'd0;
        match = (m_mode == 3) && (m_quiet == 0) && (bus_if.learn_note != 10'd0) &&
                (bus_if.pin_note == bus_if.learn_note);
        exp_hit = match && !m_match_prev;
        m_match_prev = match;
        if (m_quiet == 0) begin
            if (req != m_mode) begin
                m_pending = req;
                m_quiet   = MUTE + 1;
            end
        end else if (m_quiet == 1) begin
            m_quiet = 0;
            m_mode  = m_pending;
        end else if (req != m_pending) begin
            m_pending = req;
            m_quiet   = MUTE + 1;
        end else begin
            m_quiet--;
        end
        case (m_mode)
            0:       src = bus_if.pin_note;
            1:       src = bus_if.db_note;
            2:       src = uart_pre;
            default: src = bus_if.pin_note;
        endcase
        exp_note = (m_quiet == 0) ? src : 10'd0;
        if (bus_if.uart_valid) begin
            m_uart_t    = cyc;
            m_uart_note = ref_decode(int'(bus_if.uart_byte));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("note_out", bus_if.note_out, exp_note);
        check("busy", 10'(bus_if.busy), 10'(m_quiet != 0));
        check("cur_mode", 10'(bus_if.cur_mode), 10'(m_mode));
        check("hit", 10'(bus_if.hit), 10'(exp_hit));
    endtask

    // Called just after a step; asserts rst mid-cycle and checks the
    // outputs clear without waiting for a clock edge.
    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_note_out", bus_if.note_out, 10'd0);
        check("rst_busy", 10'(bus_if.busy), 10'd0);
        check("rst_cur_mode", 10'(bus_if.cur_mode), 10'd0);
        check("rst_hit", 10'(bus_if.hit), 10'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int cnt;
        int commit_at;

        bus_if.mode_req   = 2'd2;
        bus_if.pin_note   = '0;
        bus_if.db_note    = '0;
        bus_if.learn_note = '0;
        bus_if.uart_byte  = '0;
        bus_if.uart_valid = 1'b0;

        // Power-on reset with UART mode already requested
        #1;
        check("por_note_out", bus_if.note_out, 10'd0);
        check("por_busy", 10'(bus_if.busy), 10'd0);
        check("por_cur_mode", 10'(bus_if.cur_mode), 10'd0);
        check("por_hit", 10'(bus_if.hit), 10'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        busy_cnt = 0;
        repeat (20) begin
            step();
            busy_cnt += int'(bus_if.busy);
        end
        check("por_busy_len", 10'(busy_cnt), 10'd17);
        check("por_mode_uart", 10'(bus_if.cur_mode), 10'd2);

        // FREE passthrough, then switch to PLAY
        bus_if.mode_req = 2'd0;
        bus_if.pin_note = 10'b0010_000100;
        repeat (20) step();
        check("free_pin", bus_if.note_out, 10'b0010_000100);
        bus_if.mode_req = 2'd1;
        bus_if.db_note  = 10'b1000_000001;
        cnt = 0;
        repeat (17) begin
            step();
            cnt += int'(bus_if.note_out == 10'd0);
        end
        check("play_mute_len", 10'(cnt), 10'd17);
        step();
        check("play_db", bus_if.note_out, 10'b1000_000001);

        // UART note hold
        bus_if.mode_req = 2'd2;
        repeat (20) step();
        bus_if.uart_byte  = 8'h0B;
        bus_if.uart_valid = 1'b1;
        step();
        bus_if.uart_valid = 1'b0;
        cnt = 0;
        repeat (12) begin
            step();
            cnt += int'(bus_if.note_out == 10'b0100_000100);
        end
        check("uart_hold_len", 10'(cnt), 10'd8);
        bus_if.uart_byte  = 8'h18;
        bus_if.uart_valid = 1'b1;
        step();
        bus_if.uart_valid = 1'b0;
        cnt = 0;
        repeat (10) begin
            step();
            cnt += int'(bus_if.note_out != 10'd0);
        end
        check("uart_bad_pitch", 10'(cnt), 10'd0);

        // Request changes mid-mute: 1 then 3 with the mute counter at 5
        bus_if.mode_req = 2'd1;
        repeat (11) step();
        bus_if.mode_req = 2'd3;
        commit_at = 0;
        for (int i = 1; i <= 25; i++) begin
            step();
            if (commit_at == 0 && bus_if.cur_mode == 2'd3) commit_at = i;
        end
        check("reload_commit", 10'(commit_at), 10'(MUTE + 2));

        // LEARN hits
        bus_if.learn_note = 10'b0010_000010;
        bus_if.pin_note   = '0;
        repeat (2) step();
        bus_if.pin_note = 10'b0010_000010;
        cnt = 0;
        repeat (5) begin
            step();
            cnt += int'(bus_if.hit);
        end
        check("learn_hit1", 10'(cnt), 10'd1);
        bus_if.pin_note = '0;
        repeat (2) step();
        bus_if.pin_note = 10'b0010_000010;
        repeat (3) begin
            step();
            cnt += int'(bus_if.hit);
        end
        check("learn_hit2", 10'(cnt), 10'd2);

        // Reset in the middle of a mute (counter at 3)
        bus_if.mode_req = 2'd1;
        repeat (13) step();
        pulse_reset();
        busy_cnt = 0;
        repeat (20) begin
            step();
            busy_cnt += int'(bus_if.busy);
        end
        check("rst_mid_mute_busy", 10'(busy_cnt), 10'd17);
        check("rst_mid_mute_mode", 10'(bus_if.cur_mode), 10'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus_if.uart_valid = 1'b0;
            if ($urandom_range(599) == 0) pulse_reset();
            if ($urandom_range(39) == 0) bus_if.mode_req = 2'($urandom_range(3));
            if ($urandom_range(11) == 0)
                bus_if.learn_note = ($urandom_range(3) == 0) ? 10'd0 : 10'($urandom);
            bus_if.pin_note = ($urandom_range(2) == 0) ? bus_if.learn_note : 10'($urandom);
            bus_if.db_note  = 10'($urandom);
            if ($urandom_range(14) == 0) begin
                bus_if.uart_byte  = 8'($urandom);
                bus_if.uart_valid = 1'b1;
            end
            step();
        end
        bus_if.uart_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
